alu_mul_seq: RTL and testbench

Sequential signed fixed-point multiplier in the execute stage of the reverb processor, used for tap-gain and feedback-coefficient products. It accepts two operands on a one-cycle start pulse and runs a radix-2 shift-add over `bits` cycles. It then rounds and scales the product to the datapath Q format and returns it to the same width. Its `result` feeds the multiply slot of the ALU result multiplexer, and the control unit stalls the pipeline while `busy` is high.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_mul_round.sv | 54 +++++
 rtl/alu_mul_seq.sv | 129 ++++++++++++
 tb/tb_alu_mul_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared types and constants for the reverb-processor ALU slice.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_BITS = 32;
    localparam int ALU_FRAC = 16;

    // Clamp limits of the default 32-bit datapath
    localparam logic [31:0] ALU_SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] ALU_SAT_NEG = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } alu_mul_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_round.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mul_round
//  Purpose  : Rounds and scales a magnitude product to the Q format, applies
//             the sign, and either saturates or wraps on overflow.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mul_round
    import alu_pkg::*;
#(
    parameter int BITS   = ALU_BITS,
    parameter int FRAC   = ALU_FRAC,
    parameter bit SAT_EN = 1'b0
) (
    input  logic [2*BITS-1:0] i_acc,
    input  logic              i_sign,
    output logic [BITS-1:0]   o_result,
    output logic              o_overflow
);

    localparam int W = 2*BITS + 1;
    localparam logic [W-1:0] C_NEG_LIM = {{(BITS+1){1'b0}}, 1'b1, {(BITS-1){1'b0}}};
    localparam logic [W-1:0] C_POS_LIM = C_NEG_LIM - W'(1);

    logic [W-1:0]    w_mag;
    logic [BITS-1:0] w_val;

    generate
        if (FRAC > 0) begin : g_round
            // Adding half an LSB to a magnitude rounds half away from zero
            localparam logic [W-1:0] C_HALF = W'(1) << (FRAC - 1);
            logic [W-1:0] w_sum;
            assign w_sum = {1'b0, i_acc} + C_HALF;
            assign w_mag = w_sum >> FRAC;
        end else begin : g_noround
            assign w_mag = {1'b0, i_acc};
        end
    endgenerate

    assign o_overflow = i_sign ? (w_mag > C_NEG_LIM) : (w_mag > C_POS_LIM);
    assign w_val      = i_sign ? -w_mag[BITS-1:0] : w_mag[BITS-1:0];

    generate
        if (SAT_EN) begin : g_sat
            assign o_result = o_overflow ? (i_sign ? {1'b1, {(BITS-1){1'b0}}}
                                                   : {1'b0, {(BITS-1){1'b1}}})
                                         : w_val;
        end else begin : g_wrap
            assign o_result = w_val;
        end
    endgenerate

endmodule : alu_mul_round
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mul_seq
//  Purpose  : Sequential radix-2 signed fixed-point multiplier; one product
//             every BITS+2 cycles. Define ALU_MUL_SAT_EN to saturate on
//             overflow instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int BITS = ALU_BITS,
    parameter int FRAC = ALU_FRAC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] result,
    output logic            busy,
    output logic            done,
    output logic            overflow
);

`ifdef ALU_MUL_SAT_EN
    localparam bit C_SAT_EN = 1'b1;
`else
    localparam bit C_SAT_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(BITS + 1);

    alu_mul_state_e    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*BITS-1:0] mcand_q, mcand_d;
    logic [BITS-1:0]   mplier_q, mplier_d;
    logic [2*BITS-1:0] acc_q, acc_d;
    logic              sign_q, sign_d;
    logic [BITS-1:0]   result_q, result_d;
    logic              ovf_q, ovf_d;

    logic [BITS-1:0]   w_abs_a, w_abs_b;
    logic [2*BITS-1:0] w_acc_step;
    logic [BITS-1:0]   w_rnd_result;
    logic              w_rnd_ovf;

    // The most negative operand maps to 2^(BITS-1), which fits unsigned
    assign w_abs_a    = a[BITS-1] ? -a : a;
    assign w_abs_b    = b[BITS-1] ? -b : b;
    assign w_acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Rounding sees the final partial sum so result lands with FIN entry
    alu_mul_round #(
        .BITS   (BITS),
        .FRAC   (FRAC),
        .SAT_EN (C_SAT_EN)
    ) u_round (
        .i_acc      (w_acc_step),
        .i_sign     (sign_q),
        .o_result   (w_rnd_result),
        .o_overflow (w_rnd_ovf)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    mcand_d  = {{BITS{1'b0}}, w_abs_a};
                    mplier_d = w_abs_b;
                    acc_d    = '0;
                    cnt_d    = CNT_W'(BITS);
                    sign_d   = a[BITS-1] ^ b[BITS-1];
                end
            end
            ST_RUN: begin
                acc_d    = w_acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = ST_FIN;
                    result_d = w_rnd_result;
                    ovf_d    = w_rnd_ovf;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result   = result_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_FIN);

endmodule : alu_mul_seq
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mul_seq
//  Purpose  : Self-checking bench for alu_mul_seq (BITS=32, FRAC=16) using a
//             multiply-based reference model and an expected-result queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        overflow;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    alu_mul_seq #(.BITS(32), .FRAC(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib);
        logic [31:0] ua, ub;
        logic [63:0] p, m, v;
        logic        s;
        exp_t        e;
        s  = ia[31] ^ ib[31];
        ua = ia[31] ? (~ia + 32'd1) : ia;
        ub = ib[31] ? (~ib + 32'd1) : ib;
        p  = {32'd0, ua} * {32'd0, ub};
        m  = (p + 64'h8000) >> 16;
        e.ovf = s ? (m > 64'h8000_0000) : (m > 64'h7FFF_FFFF);
        v  = s ? (~m + 64'd1) : m;
        e.res = v[31:0];
`ifdef ALU_MUL_SAT_EN
        if (e.ovf) e.res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding product
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done result=%h ovf=%b", result, overflow);
            end else begin
                mon_e = q.pop_front();
                if (result !== mon_e.res || overflow !== mon_e.ovf) begin
                    errors++;
                    $display("FAIL scoreboard got result=%h ovf=%b want result=%h ovf=%b",
                             result, overflow, mon_e.res, mon_e.ovf);
                end
            end
        end
    end

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input bit push);
        start = 1'b1;
        a     = ia;
        b     = ib;
        if (push) q.push_back(model(ia, ib));
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_latency(input string name, input int n, input int want);
        checks++;
        if (n !== want) begin
            errors++;
            $display("FAIL %s done_after=%0d want=%0d", name, n, want);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, overflow, result} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b ovf=%b result=%h want all 0",
                     busy, done, overflow, result);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL after_reset busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        @(posedge clk); #1;
        issue(32'h0001_8000, 32'h0002_0000, 1'b1);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== (c <= 32) || done !== (c == 33)) begin
                errors++;
                $display("FAIL timing cycle=%0d busy=%b done=%b want busy=%b done=%b",
                         c, busy, done, c <= 32, c == 33);
            end
        end
        checks++;
        if (result !== 32'h0003_0000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mul_1p5x2 result=%h ovf=%b want 00030000 0", result, overflow);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (result !== 32'h0003_0000 || done !== 1'b0) begin
            errors++;
            $display("FAIL hold result=%h done=%b want 00030000 0", result, done);
        end
    endtask

    task automatic test_vectors;
        logic [31:0] va [7] = '{32'hFFFF_8000, 32'h0000_0001, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0001_0000};
        logic [31:0] vb [7] = '{32'h0000_4000, 32'h0000_8000, 32'h0000_8000,
                               32'h0001_0000, 32'hFFFF_0000, 32'h1234_5678, 32'hFFFF_0000};
        int n;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            issue(va[i], vb[i], 1'b1);
            wait_done(n);
            check_latency("vector_latency", n, 33);
        end
    endtask

    task automatic test_overflow;
        int n;
        @(posedge clk); #1;
        issue(32'h7FFF_0000, 32'h0002_0000, 1'b1);
        wait_done(n);
        check_latency("ovf_latency", n, 33);
        checks++;
`ifdef ALU_MUL_SAT_EN
        if (overflow !== 1'b1 || result !== 32'h7FFF_FFFF) begin
`else
        if (overflow !== 1'b1 || result !== 32'hFFFE_0000) begin
`endif
            errors++;
            $display("FAIL overflow_pos result=%h ovf=%b", result, overflow);
        end
        @(posedge clk); #1;
        issue(32'h8000_0000, 32'h0002_0000, 1'b1);
        wait_done(n);
        check_latency("ovf_neg_latency", n, 33);
    endtask

    task automatic test_ignore_start;
        int n;
        @(posedge clk); #1;
        issue(32'h0003_0000, 32'hFFFE_0000, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; a = 32'h0100_0000; b = 32'h0100_0000;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        check_latency("ignore_first_done", n, 28);
        @(posedge clk); #1;
        issue(32'h0000_4000, 32'h0000_4000, 1'b1);
        wait_done(n);
        check_latency("restart_cycle34_done", n, 33);
    endtask

    task automatic test_reset_abort;
        int n;
        int cnt;
        @(posedge clk); #1;
        issue(32'h0005_0000, 32'h0003_0000, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL abort busy=%b done=%b result=%h ovf=%b want 0 0 0 0",
                     busy, done, result, overflow);
        end
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL abort_no_done pulses=%0d want 0", cnt);
        end
        @(posedge clk); #1;
        issue(32'hFFFE_8000, 32'hFFFF_C000, 1'b1);
        wait_done(n);
        check_latency("after_abort_latency", n, 33);
    endtask

    task automatic test_back_to_back;
        int n;
        @(posedge clk); #1;
        start = 1'b1; a = 32'h0002_0000; b = 32'h0002_8000;
        q.push_back(model(a, b));
        @(posedge clk); #1;
        a = 32'hFFF0_0000; b = 32'h0000_1000;
        q.push_back(model(a, b));
        wait_done(n);
        check_latency("b2b_first", n, 33);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 32'h0000_0003; b = 32'h0000_AAAA;
        q.push_back(model(a, b));
        wait_done(n);
        check_latency("b2b_second", n, 33);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        check_latency("b2b_third", n, 33);
    endtask

    task automatic test_random;
        int n;
        logic [31:0] r;
        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            @(posedge clk); #1;
            issue($urandom, {{12{r[19]}}, r[19:0]}, 1'b1);
            wait_done(n);
            check_latency("random_latency", n, 33);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_overflow();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain outstanding=%0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_mul_seq
`default_nettype wire
